tour_cmd: RTL and testbench

//  Command initiator facing cmd_proc. Idle: forwards UART cmds (cmd_UART/cmd_rdy_UART) to cmd_proc.

---
 rtl/tour_cmd.sv | 110 +++++++++++
 tb/tb_tour_cmd.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/tour_cmd.sv
// Knight's-tour command initiator: forwards UART commands when idle,
// otherwise plays the solved tour to cmd_proc as vertical/horizontal legs.
module tour_cmd #(
  parameter int NUM_MOVES = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_tour,
  input  logic [7:0]  move,
  output logic [4:0]  mv_indx,
  input  logic [15:0] cmd_UART,
  input  logic        cmd_rdy_UART,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic [7:0]  resp
);

  localparam logic [4:0] LAST = 5'(NUM_MOVES - 1);

  typedef enum logic [2:0] {
    IDLE, VERT, WAITV, HORZ, WAITH
  } state_t;

  state_t      r_state;
  logic [15:0] r_cmd;
  logic        r_cmd_rdy;
  logic [4:0]  r_mv_indx;
  logic [15:0] w_vleg;
  logic [15:0] w_hleg;
  logic        w_last;

  // Lowest set bit of the one-hot move selects the leg pair.
  always_comb begin
    w_vleg = 16'h2000;
    w_hleg = 16'h3000;
    priority case (1'b1)
      move[0]: begin w_vleg = 16'h2002; w_hleg = 16'h3BF1; end
      move[1]: begin w_vleg = 16'h2002; w_hleg = 16'h33F1; end
      move[2]: begin w_vleg = 16'h2001; w_hleg = 16'h33F2; end
      move[3]: begin w_vleg = 16'h27F1; w_hleg = 16'h33F2; end
      move[4]: begin w_vleg = 16'h27F2; w_hleg = 16'h33F1; end
      move[5]: begin w_vleg = 16'h27F2; w_hleg = 16'h3BF1; end
      move[6]: begin w_vleg = 16'h27F1; w_hleg = 16'h3BF2; end
      move[7]: begin w_vleg = 16'h2001; w_hleg = 16'h3BF2; end
      default: ;
    endcase
  end

  assign w_last = (r_mv_indx == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cmd     <= 16'h0000;
      r_cmd_rdy <= 1'b0;
      r_mv_indx <= 5'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_tour) begin
            r_mv_indx <= 5'd0;
            r_state   <= VERT;
          end
        end
        VERT: begin
          r_cmd <= w_vleg;
          if (clr_cmd_rdy && r_cmd_rdy) begin
            r_cmd_rdy <= 1'b0;
            r_state   <= WAITV;
          end else begin
            r_cmd_rdy <= 1'b1;
          end
        end
        WAITV: begin
          if (send_resp)
            r_state <= HORZ;
        end
        HORZ: begin
          r_cmd <= w_hleg;
          if (clr_cmd_rdy && r_cmd_rdy) begin
            r_cmd_rdy <= 1'b0;
            r_state   <= WAITH;
          end else begin
            r_cmd_rdy <= 1'b1;
          end
        end
        WAITH: begin
          if (send_resp) begin
            if (w_last) begin
              r_state <= IDLE;
            end else begin
              r_mv_indx <= r_mv_indx + 5'd1;
              r_state   <= VERT;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mv_indx = r_mv_indx;
  assign cmd     = (r_state == IDLE) ? cmd_UART : r_cmd;
  assign cmd_rdy = (r_state == IDLE) ? cmd_rdy_UART : r_cmd_rdy;
  assign resp    = ((r_state == IDLE) || (r_state == WAITH && w_last))
                   ? 8'hA5 : 8'h5A;

endmodule

// File: tb/tb_tour_cmd.sv
// Randomized bench for tour_cmd: emulates cmd_proc and checks every leg
// against a dx/dy knight-move model.
module tb_tour_cmd;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_tour;
  logic [7:0]  move;
  logic [4:0]  mv_indx;
  logic [15:0] cmd_UART;
  logic        cmd_rdy_UART;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [7:0]  resp;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] mem [32];
  int DX [8] = '{1, -1, -2, -2, -1, 1, 2, 2};
  int DY [8] = '{2, 2, 1, -1, -2, -2, -1, 1};

  always #5 clk = ~clk;

  assign move = mem[mv_indx];

  tour_cmd dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_tour   (start_tour),
    .move         (move),
    .mv_indx      (mv_indx),
    .cmd_UART     (cmd_UART),
    .cmd_rdy_UART (cmd_rdy_UART),
    .cmd          (cmd),
    .cmd_rdy      (cmd_rdy),
    .clr_cmd_rdy  (clr_cmd_rdy),
    .send_resp    (send_resp),
    .resp         (resp)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] leg(input logic [7:0] mv, input bit horiz);
    int k;
    int d;
    logic [7:0] head;
    logic [3:0] mag;
    k = -1;
    for (int b = 7; b >= 0; b--)
      if (mv[b]) k = b;
    if (k < 0) return horiz ? 16'h3000 : 16'h2000;
    d = horiz ? DX[k] : DY[k];
    mag = 4'((d < 0) ? -d : d);
    if (horiz) head = (d > 0) ? 8'hBF : 8'h3F;
    else       head = (d > 0) ? 8'h00 : 8'h7F;
    return {(horiz ? 4'h3 : 4'h2), head, mag};
  endfunction

  task automatic fill_mem();
    int r;
    for (int i = 0; i < 32; i++) begin
      r = int'($urandom % 8);
      if (r == 0)      mem[i] = 8'h00;
      else if (r == 1) mem[i] = 8'($urandom);
      else             mem[i] = 8'h01 << ($urandom % 8);
    end
  endtask

  task automatic wait_rdy(input string tag);
    int n;
    n = 0;
    while (cmd_rdy !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(n < 20), 32'd1);
  endtask

  // Plays cmd_proc for one tour; stop_i >= 0 returns in WAITH at that index.
  task automatic run_tour(input int stop_i);
    logic [15:0] exp;
    logic [15:0] junk;
    int k;
    @(negedge clk);
    start_tour = 1'b1;
    @(negedge clk);
    start_tour = 1'b0;
    for (int i = 0; i < 24; i++) begin
      for (int h = 0; h < 2; h++) begin
        exp = leg(mem[i], h[0]);
        wait_rdy(h ? "rdy_h" : "rdy_v");
        check("cmd", 32'(cmd), 32'(exp));
        check("idx", 32'(mv_indx), i);
        check("resp_busy", 32'(resp), 32'h5A);
        k = int'($urandom % 3);
        for (int c = 0; c < k; c++) begin
          start_tour   = 1'($urandom);
          send_resp    = 1'($urandom);
          cmd_rdy_UART = 1'b1;
          junk         = 16'($urandom);
          cmd_UART     = junk;
          @(negedge clk);
          start_tour   = 1'b0;
          send_resp    = 1'b0;
          cmd_rdy_UART = 1'b0;
          check("cmd_hold", 32'(cmd), 32'(exp));
          check("rdy_hold", 32'(cmd_rdy), 32'd1);
          check("idx_hold", 32'(mv_indx), i);
        end
        clr_cmd_rdy = 1'b1;
        send_resp   = 1'($urandom);
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        send_resp   = 1'b0;
        check("rdy_clr", 32'(cmd_rdy), 32'd0);
        k = 1 + int'($urandom % 2);
        for (int c = 0; c < k; c++) begin
          clr_cmd_rdy  = 1'($urandom);
          cmd_rdy_UART = 1'($urandom);
          @(negedge clk);
          clr_cmd_rdy  = 1'b0;
          cmd_rdy_UART = 1'b0;
        end
        check("rdy_wait", 32'(cmd_rdy), 32'd0);
        check("cmd_wait", 32'(cmd), 32'(exp));
        if (h == 1 && i == stop_i) return;
        check("resp_sr", 32'(resp), (h == 1 && i == 23) ? 32'hA5 : 32'h5A);
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
      end
    end
  endtask

  task automatic check_idle(input string tag, input int idx);
    logic [15:0] v;
    v = 16'($urandom);
    cmd_UART     = v;
    cmd_rdy_UART = 1'b1;
    #1;
    check({tag, "_cmd"}, 32'(cmd), 32'(v));
    check({tag, "_rdy"}, 32'(cmd_rdy), 32'd1);
    check({tag, "_resp"}, 32'(resp), 32'hA5);
    check({tag, "_idx"}, 32'(mv_indx), idx);
    cmd_rdy_UART = 1'b0;
    #1;
    check({tag, "_rdy0"}, 32'(cmd_rdy), 32'd0);
  endtask

  initial begin
    rst_n        = 1'b0;
    start_tour   = 1'b0;
    cmd_UART     = 16'h0000;
    cmd_rdy_UART = 1'b1;
    clr_cmd_rdy  = 1'b0;
    send_resp    = 1'b0;
    fill_mem();
    mem[0] = 8'h01;
    mem[1] = 8'h08;
    repeat (2) @(negedge clk);
    check("rst_cmd", 32'(cmd), 32'h0000);
    check("rst_rdy", 32'(cmd_rdy), 32'd1);
    check("rst_resp", 32'(resp), 32'hA5);
    check("rst_idx", 32'(mv_indx), 32'd0);
    cmd_rdy_UART = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("idle0", 0);

    for (int t = 0; t < 3; t++) begin
      run_tour(-1);
      @(negedge clk);
      check_idle("end", 23);
      fill_mem();
    end

    run_tour(10);
    check("pre_rst_idx", 32'(mv_indx), 32'd10);
    rst_n = 1'b0;
    #1;
    check("rst_h_rdy", 32'(cmd_rdy), 32'd0);
    check_idle("rst_h", 0);
    @(negedge clk);
    rst_n = 1'b1;

    @(negedge clk);
    start_tour = 1'b1;
    @(negedge clk);
    start_tour = 1'b0;
    wait_rdy("rdy_v2");
    check("cmd_v2", 32'(cmd), 32'(leg(mem[0], 1'b0)));
    rst_n = 1'b0;
    #1;
    check("rst_v_rdy", 32'(cmd_rdy), 32'd0);
    check_idle("rst_v", 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("post", 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
